lsu_bram_port: RTL
==================

// Module: lsu_bram_port
// PURPOSE
//  Load/store front end for one port of the dual-port byte-enabled data BRAM.
//  Accepts byte-addressed RV32 load/store requests over a valid/ready handshake.
//  Drives BRAM en/we/addr/wdata, and returns aligned, sign/zero-extended load data
//  over a valid/ready response channel. Sits between the core's MEM stage and the BRAM.
// PARAMETERS
//  ADDR_WIDTH  10  BRAM word-address width; the request byte address is ADDR_WIDTH+2 bits
//  COL_WIDTH    8  BRAM column (byte lane) width; fixed at 8
//  NB_COL       4  BRAM lanes per word; fixed at 4 (32-bit data)
// PORTS
//  clk           in   1             single clock
//  reset_n       in   1             asynchronous active-low reset
//  req_valid     in   1             request present
//  req_ready     out  1             request accepted when valid&&ready
//  req_we        in   1             1=store, 0=load
//  req_size      in   2             0=byte, 1=half, 2=word, 3=illegal
//  req_unsigned  in   1             loads: zero-extend (LBU/LHU), else sign-extend
//  req_addr      in   ADDR_WIDTH+2  byte address
//  req_wdata     in   32            store data, right-justified
//  rsp_valid     out  1             response present (exactly one per accepted request)
//  rsp_ready     in   1             response consumed when valid&&ready
//  rsp_rdata     out  32            load result; 0 for stores and errors
//  rsp_err       out  1             misaligned or illegal-size request
//  mem_en        out  1             BRAM port enable
//  mem_we        out  4             BRAM byte write enables
//  mem_addr      out  ADDR_WIDTH    BRAM word address = req_addr[ADDR_WIDTH+1:2]
//  mem_wdata     out  32            lane-replicated store data
//  mem_rdata     in   32            BRAM read data; valid 1 clk after a read-enable
// BEHAVIOUR
//  - Registered state: rsp_valid, and the captured is_load/err/size/unsigned/offset[1:0].
//    Reset (async, reset_n=0) clears all of them. rsp_valid=0 immediately on reset.
//  - req_ready = !rsp_valid || rsp_ready (combinational). Back-to-back throughput is 1 req/clk.
//  - Issue (fire = req_valid && req_ready):
//    - misaligned = (size==1 && addr[0]) || (size==2 && addr[1:0]!=0) || size==3.
//    - mem_en = fire && !misaligned. No BRAM access on error.
//    - Store lanes: byte -> mem_we = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
//      half -> mem_we = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
//      word -> 4'b1111.
//    - Load: mem_we = 0.
//  - Response: rsp_valid goes 1 the clk after fire. It stays 1 until rsp_ready.
//    It clears the clk after consumption unless a new fire occurs in the same clk.
//  - Load data is formed combinationally from mem_rdata and the captured size/offset:
//    byte lane = offset, half lane = offset[1]. Sign- or zero-extend to 32 bits.
//  - Stall hold: while rsp_valid && !rsp_ready, no fire occurs, so mem_en=0.
//    The BRAM therefore holds mem_rdata, and rsp_rdata stays stable without a data register.
//  - Write-then-read to the same word on consecutive clks returns the new data.
//  - Reset mid-transaction: a pending response is dropped. No BRAM side effects beyond
//    stores already issued.
// TESTING
//  1. SW 0xDEADBEEF @0x010; LW @0x010 -> mem_we=1111, then rsp_rdata=0xDEADBEEF, err=0.
//  2. SB 0x7F @0x013 -> mem_we=1000, mem_wdata=0x7F7F7F7F. LB @0x013 -> 0x0000007F.
//     SB 0x80, then LB -> 0xFFFFFF80; LBU -> 0x00000080.
//  3. LH @0x012 of word 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
//     LH @0x011 -> rsp_err=1, rdata=0, mem_en never asserted.
//  4. Issue LW @0x010 and hold rsp_ready=0 for 5 clks.
//     -> req_ready=0, mem_en=0, rsp_rdata stable. Release -> next queued req fires the same clk.
//  5. 8 back-to-back LWs with rsp_ready=1 -> 8 responses on 8 consecutive clks, in order.
//  6. Assert reset_n=0 while rsp_valid=1 -> rsp_valid=0 asynchronously, no spurious response.

Source files
------------

// File: rtl/lsu_bram_port.sv
// rtl/lsu_bram_port.sv - load/store front end for one byte-enabled data BRAM port
// Issues aligned BRAM accesses and returns extended load data over a valid/ready response.
module lsu_bram_port #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [ADDR_WIDTH+1:0]         req_addr,
  input  logic [COL_WIDTH*NB_COL-1:0]   req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [COL_WIDTH*NB_COL-1:0]   rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_en,
  output logic [NB_COL-1:0]             mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [COL_WIDTH*NB_COL-1:0]   mem_wdata,
  input  logic [COL_WIDTH*NB_COL-1:0]   mem_rdata
);

  logic       rsp_valid_q, rsp_valid_d;
  logic       is_load_q, is_load_d;
  logic       err_q, err_d;
  logic [1:0] size_q, size_d;
  logic       unsigned_q, unsigned_d;
  logic [1:0] offset_q, offset_d;

  logic        misaligned;
  logic        fire;
  logic [3:0]  lanes;
  logic [31:0] wdata_rep;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    misaligned = (req_size == 2'd3) ||
                 (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    req_ready  = !rsp_valid_q || rsp_ready;
    fire       = req_valid && req_ready;

    lanes     = 4'b1111;
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        lanes     = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lanes     = 4'b0011 << req_addr[1:0];
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        lanes     = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase

    mem_en    = fire && !misaligned;
    mem_we    = (fire && !misaligned && req_we) ? lanes : 4'b0000;
    mem_addr  = req_addr[ADDR_WIDTH+1:2];
    mem_wdata = wdata_rep;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    is_load_d   = is_load_q;
    err_d       = err_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    offset_d    = offset_q;
    if (fire) begin
      rsp_valid_d = 1'b1;
      is_load_d   = !req_we;
      err_d       = misaligned;
      size_d      = req_size;
      unsigned_d  = req_unsigned;
      offset_d    = req_addr[1:0];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      is_load_q   <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      offset_q    <= 2'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      is_load_q   <= is_load_d;
      err_q       <= err_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      offset_q    <= offset_d;
    end
  end

  // No data register: a stalled response relies on the BRAM holding its output while mem_en=0.
  always_comb begin
    case (offset_q)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      2'd0:    load_data = {{24{lane_byte[7] && !unsigned_q}}, lane_byte};
      2'd1:    load_data = {{16{lane_half[15] && !unsigned_q}}, lane_half};
      default: load_data = mem_rdata;
    endcase

    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_valid_q && err_q;
    rsp_rdata = (rsp_valid_q && is_load_q && !err_q) ? load_data : 32'd0;
  end

endmodule
